prog_pulse_gen: RTL

PROG_PULSE_GEN -- requirements
Module: prog_pulse_gen

---
 rtl/prog_pulse_gen_pkg.sv | 17 +
 rtl/pulse_phase_counter.sv | 28 ++
 rtl/prog_pulse_gen.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/prog_pulse_gen_pkg.sv
// Shared types for the programmable pulse generator: sequence modes and FSM states.
package prog_pulse_gen_pkg;

  typedef enum logic [1:0] {
    CONT    = 2'b00,
    ONESHOT = 2'b01,
    BURST   = 2'b10,
    RSVD    = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } state_t;

endpackage

// File: rtl/pulse_phase_counter.sv
// Down-counter timing one HIGH or LOW phase; tc flags the last cycle of the phase.
module pulse_phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // Saturating at zero keeps an aborted phase from wrapping while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(1));

endmodule

// File: rtl/prog_pulse_gen.sv
// Programmable pulse generator: continuous, one-shot or burst pulse trains
// with latched period/width configuration and start validation.
module prog_pulse_gen
  import prog_pulse_gen_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   width,
  input  logic [BURST_W-1:0] burst_len,
  output logic               pulse,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  state_t             state;
  state_t             next_state;
  mode_t              mode_in;
  mode_t              mode_q;
  logic [CNT_W-1:0]   period_q;
  logic [CNT_W-1:0]   width_q;
  logic [BURST_W-1:0] burst_len_q;
  logic [BURST_W-1:0] pulse_cnt;

  logic               cfg_ok;
  logic               accept;
  logic               seq_last;
  logic               phase_tc;
  logic               cnt_load;
  logic               cnt_dec;
  logic [CNT_W-1:0]   cnt_val;
  logic               pulse_cnt_inc;
  logic               pulse_d;
  logic               done_d;
  logic               cfg_err_d;

  assign mode_in = mode_t'(mode);

  // width<period together with period<2^CNT_W guarantees both phase loads fit the counter.
  assign cfg_ok = (width != '0) &&
                  (period >= CNT_W'(2)) &&
                  (width < period) &&
                  (mode_in != RSVD) &&
                  ((mode_in != BURST) || (burst_len != '0));

  assign accept = (state == IDLE) && start && en && cfg_ok;

  assign seq_last = (mode_q == ONESHOT) ||
                    ((mode_q == BURST) && (pulse_cnt == (burst_len_q - BURST_W'(1))));

  assign busy = (state != IDLE);

  pulse_phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .tc       (phase_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = HIGH;
        end
      end
      HIGH: begin
        if (!en) begin
          next_state = IDLE;
        end else if (phase_tc) begin
          next_state = LOW;
        end
      end
      LOW: begin
        if (!en) begin
          next_state = IDLE;
        end else if (phase_tc) begin
          next_state = seq_last ? IDLE : HIGH;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Pulse is registered from next_state so it rises on the accepting edge.
  always_comb begin
    pulse_d       = (next_state == HIGH);
    done_d        = 1'b0;
    cfg_err_d     = 1'b0;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    cnt_val       = '0;
    pulse_cnt_inc = 1'b0;
    case (state)
      IDLE: begin
        cfg_err_d = start && en && !cfg_ok;
        if (accept) begin
          cnt_load = 1'b1;
          cnt_val  = width;
        end
      end
      HIGH: begin
        if (en) begin
          if (phase_tc) begin
            cnt_load = 1'b1;
            cnt_val  = period_q - width_q;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      LOW: begin
        if (en) begin
          if (phase_tc) begin
            if (seq_last) begin
              done_d = 1'b1;
            end else begin
              cnt_load      = 1'b1;
              cnt_val       = width_q;
              pulse_cnt_inc = (mode_q == BURST);
            end
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q      <= CONT;
      period_q    <= '0;
      width_q     <= '0;
      burst_len_q <= '0;
    end else if (accept) begin
      mode_q      <= mode_in;
      period_q    <= period;
      width_q     <= width;
      burst_len_q <= burst_len;
    end
  end

  // Counts completed pulses of a burst; only advances in BURST mode so it never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse_cnt <= '0;
    end else if (accept) begin
      pulse_cnt <= '0;
    end else if (pulse_cnt_inc) begin
      pulse_cnt <= pulse_cnt + BURST_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse   <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      pulse   <= pulse_d;
      done    <= done_d;
      cfg_err <= cfg_err_d;
    end
  end

endmodule
